// File: rtl/scr1_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// scr1_mem_arbiter_pkg
//   Shared scr1 memory-interface definitions: response codes, command and
//   access-width encodings, bus widths, and a small helper that tells
//   whether a response code ends a transfer.
// ---------------------------------------------------------------------------
package scr1_mem_arbiter_pkg;

  localparam int unsigned SCR1_MEM_AWIDTH = 32;
  localparam int unsigned SCR1_MEM_DWIDTH = 32;

  // Response codes
  localparam logic [1:0] SCR1_MEM_RESP_NOTRDY = 2'b00;
  localparam logic [1:0] SCR1_MEM_RESP_RDY_OK = 2'b01;
  localparam logic [1:0] SCR1_MEM_RESP_RDY_ER = 2'b10;

  // Command encoding
  localparam logic SCR1_MEM_CMD_RD = 1'b0;
  localparam logic SCR1_MEM_CMD_WR = 1'b1;

  // Access width encoding
  localparam logic [1:0] SCR1_MEM_WIDTH_BYTE  = 2'b00;
  localparam logic [1:0] SCR1_MEM_WIDTH_HWORD = 2'b01;
  localparam logic [1:0] SCR1_MEM_WIDTH_WORD  = 2'b10;

  // An OK or error response both complete the outstanding transfer.
  function automatic logic scr1_mem_resp_done(input logic [1:0] resp);
    return (resp == SCR1_MEM_RESP_RDY_OK) || (resp == SCR1_MEM_RESP_RDY_ER);
  endfunction

endpackage

// File: rtl/scr1_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// scr1_mem_arbiter_if
//   One scr1 memory port (request + response channel).
//   Handshake: a request is accepted in the cycle where req & req_ack = 1;
//   the requester holds req and its payload stable until that cycle.
//   Responses arrive later on resp/rdata (00 = none, 01 = OK, 10 = error).
//   modport master : drives req/cmd/width/addr/wdata, receives ack/resp
//   modport slave  : the opposite side
// ---------------------------------------------------------------------------
interface scr1_mem_arbiter_if;
  import scr1_mem_arbiter_pkg::*;

  logic                       req;
  logic                       cmd;
  logic [1:0]                 width;
  logic [SCR1_MEM_AWIDTH-1:0] addr;
  logic [SCR1_MEM_DWIDTH-1:0] wdata;
  logic                       req_ack;
  logic [SCR1_MEM_DWIDTH-1:0] rdata;
  logic [1:0]                 resp;

  modport master (
    output req, cmd, width, addr, wdata,
    input  req_ack, rdata, resp
  );

  modport slave (
    input  req, cmd, width, addr, wdata,
    output req_ack, rdata, resp
  );
endinterface

// File: rtl/scr1_arb_rr2.sv
// ---------------------------------------------------------------------------
// scr1_arb_rr2
//   Two-way grant with a priority pointer and a grant lock.
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset
//     rr_en        : 1 = pointer moves to the other master after a handshake,
//                    0 = pointer stays on master 0 (fixed priority)
//     req0, req1   : master requests
//     s_req        : request actually presented on the shared port
//     s_req_ack    : shared port acknowledge
//     grant        : selected master (0 when nobody requests)
//     dbg_ptr      : priority pointer, dbg_lock : lock valid
// ---------------------------------------------------------------------------
module scr1_arb_rr2 (
  input  logic clk,
  input  logic rst_n,
  input  logic rr_en,
  input  logic req0,
  input  logic req1,
  input  logic s_req,
  input  logic s_req_ack,
  output logic grant,
  output logic dbg_ptr,
  output logic dbg_lock
);

  logic ptr;
  logic lock_vld;
  logic lock_mst;
  logic lock_hit;

  // The lock only holds while its master still requests.
  assign lock_hit = lock_vld && (lock_mst ? req1 : req0);

  always_comb begin
    grant = 1'b0;
    if (lock_hit) begin
      grant = lock_mst;
    end else if (req0 && req1) begin
      grant = ptr;
    end else if (req1) begin
      grant = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= 1'b0;
      lock_vld <= 1'b0;
      lock_mst <= 1'b0;
    end else begin
      // A presented but unacknowledged request pins the grant next cycle.
      lock_vld <= s_req && !s_req_ack;
      lock_mst <= grant;
      if (rr_en && s_req && s_req_ack) begin
        ptr <= ~grant;
      end
    end
  end

  assign dbg_ptr  = ptr;
  assign dbg_lock = lock_vld;

endmodule

// File: rtl/scr1_mem_arbiter.sv
// ---------------------------------------------------------------------------
// scr1_mem_arbiter
//   Shares one scr1 memory port between two masters, one transfer
//   outstanding at a time.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     m0, m1     : master-side ports (arbiter acts as their slave)
//     s          : shared port towards memory (arbiter acts as master)
//     dbg_state  : FSM state (0 = IDLE, 1 = BUSY)
//     dbg_owner  : master owning the outstanding transfer
//   Parameter SCR1_ARB_RR: 1 = round-robin, 0 = fixed priority (m0 wins).
//   A new request may issue while idle or in the cycle the outstanding
//   transfer completes, so completion and the next issue can overlap.
// ---------------------------------------------------------------------------
module scr1_mem_arbiter
  import scr1_mem_arbiter_pkg::*;
#(
  parameter int unsigned SCR1_ARB_RR = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  scr1_mem_arbiter_if.slave   m0,
  scr1_mem_arbiter_if.slave   m1,
  scr1_mem_arbiter_if.master  s,
  output logic                dbg_state,
  output logic                dbg_owner
);

  typedef logic [0:0] arb_state_t;
  typedef logic       mst_sel_t;

  localparam arb_state_t ST_IDLE = 1'b0;
  localparam arb_state_t ST_BUSY = 1'b1;
  localparam mst_sel_t   MST_M0  = 1'b0;
  localparam mst_sel_t   MST_M1  = 1'b1;

  arb_state_t state;
  mst_sel_t   owner;
  mst_sel_t   grant;
  logic       resp_done;
  logic       window_open;
  logic       gnt_req;
  logic       s_req_int;
  logic       handshake;
  logic       busy_live;
  logic       arb_ptr;
  logic       arb_lock;

  scr1_arb_rr2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .rr_en     (SCR1_ARB_RR != 0),
    .req0      (m0.req),
    .req1      (m1.req),
    .s_req     (s_req_int),
    .s_req_ack (s.req_ack),
    .grant     (grant),
    .dbg_ptr   (arb_ptr),
    .dbg_lock  (arb_lock)
  );

  assign resp_done   = scr1_mem_resp_done(s.resp);
  // rst_n gates the outputs so they go quiet in the same cycle reset lands.
  assign window_open = rst_n && ((state == ST_IDLE) || resp_done);
  assign gnt_req     = (grant == MST_M1) ? m1.req : m0.req;
  assign s_req_int   = window_open && gnt_req;
  assign handshake   = s_req_int && s.req_ack;

  // Request channel
  assign s.req   = s_req_int;
  assign s.cmd   = (grant == MST_M1) ? m1.cmd   : m0.cmd;
  assign s.width = (grant == MST_M1) ? m1.width : m0.width;
  assign s.addr  = (grant == MST_M1) ? m1.addr  : m0.addr;
  assign s.wdata = (grant == MST_M1) ? m1.wdata : m0.wdata;

  assign m0.req_ack = s.req_ack && window_open && (grant == MST_M0);
  assign m1.req_ack = s.req_ack && window_open && (grant == MST_M1);

  // Response channel: only the owner of a live transfer sees the response;
  // anything arriving while idle is dropped.
  assign busy_live = rst_n && (state == ST_BUSY);

  assign m0.resp  = (busy_live && owner == MST_M0) ? s.resp  : SCR1_MEM_RESP_NOTRDY;
  assign m0.rdata = (busy_live && owner == MST_M0) ? s.rdata : '0;
  assign m1.resp  = (busy_live && owner == MST_M1) ? s.resp  : SCR1_MEM_RESP_NOTRDY;
  assign m1.rdata = (busy_live && owner == MST_M1) ? s.rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      owner <= MST_M0;
    end else if (handshake) begin
      state <= ST_BUSY;
      owner <= grant;
    end else if ((state == ST_BUSY) && resp_done) begin
      state <= ST_IDLE;
    end
  end

  assign dbg_state = state;
  assign dbg_owner = owner;

endmodule

// File: tb/tb_scr1_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_scr1_mem_arbiter
//   Directed bench for scr1_mem_arbiter. u_rr uses round-robin, u_fp fixed
//   priority. Inputs change 1 time unit after the rising edge; outputs are
//   checked on the falling edge.
// ---------------------------------------------------------------------------
module tb_scr1_mem_arbiter;

  logic clk;
  logic rst_n;
  logic rr_state, rr_owner, fp_state, fp_owner;
  int   checks;
  int   failures;

  scr1_mem_arbiter_if m0_if ();
  scr1_mem_arbiter_if m1_if ();
  scr1_mem_arbiter_if s_if ();
  scr1_mem_arbiter_if f0_if ();
  scr1_mem_arbiter_if f1_if ();
  scr1_mem_arbiter_if sf_if ();

  scr1_mem_arbiter #(.SCR1_ARB_RR(1)) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0        (m0_if),
    .m1        (m1_if),
    .s         (s_if),
    .dbg_state (rr_state),
    .dbg_owner (rr_owner)
  );

  scr1_mem_arbiter #(.SCR1_ARB_RR(0)) u_fp (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0        (f0_if),
    .m1        (f1_if),
    .s         (sf_if),
    .dbg_state (fp_state),
    .dbg_owner (fp_owner)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    m0_if.req = 0; m0_if.cmd = 0; m0_if.width = 2'b10; m0_if.addr = 0; m0_if.wdata = 0;
    m1_if.req = 0; m1_if.cmd = 0; m1_if.width = 2'b10; m1_if.addr = 0; m1_if.wdata = 0;
    f0_if.req = 0; f0_if.cmd = 0; f0_if.width = 2'b10; f0_if.addr = 0; f0_if.wdata = 0;
    f1_if.req = 0; f1_if.cmd = 0; f1_if.width = 2'b10; f1_if.addr = 0; f1_if.wdata = 0;
    s_if.req_ack = 0; s_if.rdata = 0; s_if.resp = 2'b00;
    sf_if.req_ack = 0; sf_if.rdata = 0; sf_if.resp = 2'b00;
  endtask

  task automatic do_reset();
    idle_all();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    idle_all();
    rst_n = 1'b0;

    // ---------------- reset state (request held during reset)
    #2;
    m0_if.req = 1; m1_if.req = 1; s_if.req_ack = 1; s_if.resp = 2'b01;
    #1;
    chk("rst_s_req",   s_if.req, 0);
    chk("rst_m0_ack",  m0_if.req_ack, 0);
    chk("rst_m1_ack",  m1_if.req_ack, 0);
    chk("rst_m0_resp", m0_if.resp, 0);
    chk("rst_m1_resp", m1_if.resp, 0);
    chk("rst_state",   rr_state, 0);
    chk("rst_owner",   rr_owner, 0);

    // ---------------- single read
    do_reset();
    m0_if.req = 1; m0_if.cmd = 0; m0_if.addr = 32'h0000_1000; s_if.req_ack = 1;
    @(negedge clk);
    chk("rd_c0_s_req",  s_if.req, 1);
    chk("rd_c0_s_addr", s_if.addr, 32'h0000_1000);
    chk("rd_c0_s_cmd",  s_if.cmd, 0);
    chk("rd_c0_m0_ack", m0_if.req_ack, 1);
    chk("rd_c0_m1_ack", m1_if.req_ack, 0);
    next_cycle();
    m0_if.req = 0; s_if.req_ack = 0;
    @(negedge clk);
    chk("rd_c1_state",   rr_state, 1);
    chk("rd_c1_m0_resp", m0_if.resp, 0);
    chk("rd_c1_m1_resp", m1_if.resp, 0);
    next_cycle();
    s_if.resp = 2'b01; s_if.rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rd_c2_m0_resp",  m0_if.resp, 2'b01);
    chk("rd_c2_m0_rdata", m0_if.rdata, 32'hDEAD_BEEF);
    chk("rd_c2_m1_resp",  m1_if.resp, 0);
    chk("rd_c2_m1_rdata", m1_if.rdata, 0);
    next_cycle();
    s_if.resp = 2'b00; s_if.rdata = 0;
    @(negedge clk);
    chk("rd_c3_state", rr_state, 0);

    // ---------------- round-robin contention
    do_reset();
    m0_if.req = 1; m0_if.addr = 32'h0000_00A0;
    m1_if.req = 1; m1_if.addr = 32'h0000_00B0;
    s_if.req_ack = 1;
    @(negedge clk);
    chk("rr_c0_s_addr", s_if.addr, 32'h0000_00A0);
    chk("rr_c0_m0_ack", m0_if.req_ack, 1);
    chk("rr_c0_m1_ack", m1_if.req_ack, 0);
    next_cycle();
    s_if.resp = 2'b01; s_if.rdata = 32'h11;
    @(negedge clk);
    chk("rr_c1_s_addr",   s_if.addr, 32'h0000_00B0);
    chk("rr_c1_m1_ack",   m1_if.req_ack, 1);
    chk("rr_c1_m0_ack",   m0_if.req_ack, 0);
    chk("rr_c1_m0_resp",  m0_if.resp, 2'b01);
    chk("rr_c1_m0_rdata", m0_if.rdata, 32'h11);
    chk("rr_c1_m1_resp",  m1_if.resp, 0);
    next_cycle();
    s_if.rdata = 32'h22;
    @(negedge clk);
    chk("rr_c2_s_addr",   s_if.addr, 32'h0000_00A0);
    chk("rr_c2_m0_ack",   m0_if.req_ack, 1);
    chk("rr_c2_m1_resp",  m1_if.resp, 2'b01);
    chk("rr_c2_m1_rdata", m1_if.rdata, 32'h22);
    chk("rr_c2_m0_resp",  m0_if.resp, 0);
    next_cycle();
    s_if.rdata = 32'h33;
    @(negedge clk);
    chk("rr_c3_s_addr",   s_if.addr, 32'h0000_00B0);
    chk("rr_c3_m1_ack",   m1_if.req_ack, 1);
    chk("rr_c3_m0_rdata", m0_if.rdata, 32'h33);
    chk("rr_c3_m1_rdata", m1_if.rdata, 0);

    // ---------------- grant lock
    do_reset();
    m1_if.req = 1; m1_if.addr = 32'h0000_00B4;
    @(negedge clk);
    chk("lk_c0_s_req",  s_if.req, 1);
    chk("lk_c0_s_addr", s_if.addr, 32'h0000_00B4);
    chk("lk_c0_m1_ack", m1_if.req_ack, 0);
    next_cycle();
    m0_if.req = 1; m0_if.addr = 32'h0000_00A4;
    @(negedge clk);
    chk("lk_c1_s_addr", s_if.addr, 32'h0000_00B4);
    chk("lk_c1_m0_ack", m0_if.req_ack, 0);
    next_cycle();
    @(negedge clk);
    chk("lk_c2_s_addr", s_if.addr, 32'h0000_00B4);
    next_cycle();
    s_if.req_ack = 1;
    @(negedge clk);
    chk("lk_c3_s_addr", s_if.addr, 32'h0000_00B4);
    chk("lk_c3_m1_ack", m1_if.req_ack, 1);
    chk("lk_c3_m0_ack", m0_if.req_ack, 0);
    next_cycle();
    m1_if.req = 0; s_if.resp = 2'b01;
    @(negedge clk);
    chk("lk_c4_s_addr",  s_if.addr, 32'h0000_00A4);
    chk("lk_c4_m0_ack",  m0_if.req_ack, 1);
    chk("lk_c4_m1_resp", m1_if.resp, 2'b01);
    chk("lk_c4_owner",   rr_owner, 1);
    next_cycle();
    m0_if.req = 0; s_if.req_ack = 0; s_if.resp = 2'b00;
    @(negedge clk);
    chk("lk_c5_owner", rr_owner, 0);

    // ---------------- error response with back-to-back issue
    do_reset();
    m0_if.req = 1; m0_if.cmd = 1; m0_if.width = 2'b01;
    m0_if.addr = 32'h0000_00C0; m0_if.wdata = 32'h0000_0055;
    s_if.req_ack = 1;
    @(negedge clk);
    chk("er_c0_s_cmd",   s_if.cmd, 1);
    chk("er_c0_s_width", s_if.width, 2'b01);
    chk("er_c0_s_wdata", s_if.wdata, 32'h0000_0055);
    next_cycle();
    m0_if.req = 0; m0_if.cmd = 0;
    m1_if.req = 1; m1_if.addr = 32'h0000_00D0;
    s_if.resp = 2'b10;
    @(negedge clk);
    chk("er_c1_m0_resp", m0_if.resp, 2'b10);
    chk("er_c1_m1_ack",  m1_if.req_ack, 1);
    chk("er_c1_s_addr",  s_if.addr, 32'h0000_00D0);
    chk("er_c1_m1_resp", m1_if.resp, 0);
    next_cycle();
    m1_if.req = 0; s_if.req_ack = 0; s_if.resp = 2'b01; s_if.rdata = 32'h77;
    @(negedge clk);
    chk("er_c2_owner",    rr_owner, 1);
    chk("er_c2_m1_resp",  m1_if.resp, 2'b01);
    chk("er_c2_m1_rdata", m1_if.rdata, 32'h77);
    chk("er_c2_m0_resp",  m0_if.resp, 0);
    next_cycle();
    s_if.resp = 2'b00; s_if.rdata = 0;
    @(negedge clk);
    chk("er_c3_state", rr_state, 0);

    // ---------------- reset mid-transfer
    do_reset();
    m0_if.req = 1; m0_if.addr = 32'h0000_00E0; s_if.req_ack = 1;
    @(negedge clk);
    chk("rm_c0_m0_ack", m0_if.req_ack, 1);
    next_cycle();
    m0_if.addr = 32'h0000_00E4;
    @(negedge clk);
    chk("rm_c1_state", rr_state, 1);
    chk("rm_c1_s_req", s_if.req, 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rm_rst_s_req",  s_if.req, 0);
    chk("rm_rst_m0_ack", m0_if.req_ack, 0);
    chk("rm_rst_m1_ack", m1_if.req_ack, 0);
    chk("rm_rst_state",  rr_state, 0);
    next_cycle();
    rst_n = 1'b1;
    m0_if.req = 0; s_if.req_ack = 0; s_if.resp = 2'b01; s_if.rdata = 32'h99;
    @(negedge clk);
    chk("rm_late_m0_resp",  m0_if.resp, 0);
    chk("rm_late_m0_rdata", m0_if.rdata, 0);
    chk("rm_late_m1_resp",  m1_if.resp, 0);
    chk("rm_late_state",    rr_state, 0);
    next_cycle();
    s_if.resp = 2'b00; s_if.rdata = 0;

    // ---------------- fixed priority
    do_reset();
    f0_if.req = 1; f0_if.addr = 32'h0000_0F00;
    f1_if.req = 1; f1_if.addr = 32'h0000_0F10;
    sf_if.req_ack = 1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        next_cycle();
        sf_if.resp = 2'b01; sf_if.rdata = 32'h100 + i;
      end
      @(negedge clk);
      chk("fp_s_addr", sf_if.addr, 32'h0000_0F00);
      chk("fp_m0_ack", f0_if.req_ack, 1);
      chk("fp_m1_ack", f1_if.req_ack, 0);
      if (i > 0) begin
        chk("fp_m0_rdata", f0_if.rdata, 32'h100 + i);
        chk("fp_m1_resp",  f1_if.resp, 0);
      end
    end
    next_cycle();
    idle_all();

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
